// File: rtl/mastermind_scorer.sv
// mastermind_scorer: multi-cycle Mastermind feedback engine.
// Counts exact (red) matches in one pass over the pegs, then colour-only
// (white) matches in a second pass. Per-peg "used" flags make sure each
// code peg and each guess peg is counted at most once. The block also keeps
// the guess count and the sticky win/lose status for the current game.
module mastermind_scorer #(
  parameter  int PEGS        = 4,
  parameter  int COLOR_W     = 3,
  parameter  int MAX_GUESSES = 8,
  localparam int CNT_W       = $clog2(PEGS + 1),
  localparam int GC_W        = $clog2(MAX_GUESSES + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      new_game,
  input  logic                      start,
  input  logic [PEGS*COLOR_W-1:0]   code,
  input  logic [PEGS*COLOR_W-1:0]   guess,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          red,
  output logic [CNT_W-1:0]          white,
  output logic [GC_W-1:0]           guess_count,
  output logic                      win,
  output logic                      lose
);

  localparam int IDX_W = (PEGS > 1) ? $clog2(PEGS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RED, S_WHITE, S_FINISH} state_t;

  state_t                    state_q, state_d;
  logic [PEGS*COLOR_W-1:0]   code_q, code_d;
  logic [PEGS*COLOR_W-1:0]   guess_q, guess_d;
  logic [PEGS-1:0]           code_used_q, code_used_d;
  logic [PEGS-1:0]           guess_used_q, guess_used_d;
  logic [CNT_W-1:0]          red_acc_q, red_acc_d;
  logic [CNT_W-1:0]          white_acc_q, white_acc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          red_q, red_d;
  logic [CNT_W-1:0]          white_q, white_d;
  logic [GC_W-1:0]           gc_q, gc_d;
  logic                      win_q, win_d;
  logic                      lose_q, lose_d;

  logic [COLOR_W-1:0]        code_peg;
  logic [COLOR_W-1:0]        guess_peg;
  logic                      idx_last;
  logic                      hit_found;
  logic [IDX_W-1:0]          hit_j;

  assign code_peg  = code_q[idx_q*COLOR_W +: COLOR_W];
  assign guess_peg = guess_q[idx_q*COLOR_W +: COLOR_W];
  assign idx_last  = (idx_q == IDX_W'(PEGS - 1));

  // Lowest unused code peg whose colour matches the current guess peg.
  always_comb begin
    hit_found = 1'b0;
    hit_j     = '0;
    for (int j = 0; j < PEGS; j++) begin
      if (!hit_found && !code_used_q[j] &&
          (code_q[j*COLOR_W +: COLOR_W] == guess_peg)) begin
        hit_found = 1'b1;
        hit_j     = IDX_W'(j);
      end
    end
  end

  // Next-state and datapath updates for the scoring sequence.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    guess_d      = guess_q;
    code_used_d  = code_used_q;
    guess_used_d = guess_used_q;
    red_acc_d    = red_acc_q;
    white_acc_d  = white_acc_q;
    idx_d        = idx_q;
    red_d        = red_q;
    white_d      = white_q;
    gc_d         = gc_q;
    win_d        = win_q;
    lose_d       = lose_q;

    if (new_game) begin
      // Abort anything in flight; the aborted guess never reports.
      state_d = S_IDLE;
      red_d   = '0;
      white_d = '0;
      gc_d    = '0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !win_q && !lose_q) begin
            code_d       = code;
            guess_d      = guess;
            code_used_d  = '0;
            guess_used_d = '0;
            red_acc_d    = '0;
            white_acc_d  = '0;
            idx_d        = '0;
            state_d      = S_RED;
          end
        end
        S_RED: begin
          if (code_peg == guess_peg) begin
            code_used_d[idx_q]  = 1'b1;
            guess_used_d[idx_q] = 1'b1;
            red_acc_d           = red_acc_q + CNT_W'(1);
          end
          if (idx_last) begin
            idx_d   = '0;
            state_d = S_WHITE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_WHITE: begin
          if (!guess_used_q[idx_q] && hit_found) begin
            code_used_d[hit_j] = 1'b1;
            white_acc_d        = white_acc_q + CNT_W'(1);
          end
          if (idx_last) begin
            state_d = S_FINISH;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_FINISH: begin
          red_d   = red_acc_q;
          white_d = white_acc_q;
          gc_d    = (gc_q == GC_W'(MAX_GUESSES)) ? gc_q : gc_q + GC_W'(1);
          win_d   = (red_acc_q == CNT_W'(PEGS));
          // This guess is the last allowed one when the old count is MAX-1.
          lose_d  = !win_d && (gc_q == GC_W'(MAX_GUESSES - 1));
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and result registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      code_q       <= '0;
      guess_q      <= '0;
      code_used_q  <= '0;
      guess_used_q <= '0;
      red_acc_q    <= '0;
      white_acc_q  <= '0;
      idx_q        <= '0;
      red_q        <= '0;
      white_q      <= '0;
      gc_q         <= '0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      guess_q      <= guess_d;
      code_used_q  <= code_used_d;
      guess_used_q <= guess_used_d;
      red_acc_q    <= red_acc_d;
      white_acc_q  <= white_acc_d;
      idx_q        <= idx_d;
      red_q        <= red_d;
      white_q      <= white_d;
      gc_q         <= gc_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FINISH);
  assign red         = red_q;
  assign white       = white_q;
  assign guess_count = gc_q;
  assign win         = win_q;
  assign lose        = lose_q;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Testbench for mastermind_scorer: table-driven vectors, hand-written
// multi-cycle sequences, and random guesses scored by a counting model.
module tb_mastermind_scorer;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_game;
  logic        start;
  logic [11:0] code_i;
  logic [11:0] guess_i;
  logic        busy;
  logic        done;
  logic [2:0]  red;
  logic [2:0]  white;
  logic [3:0]  gc;
  logic        win;
  logic        lose;

  logic        new_game6;
  logic        start6;
  logic [23:0] code6;
  logic [23:0] guess6;
  logic        busy6;
  logic        done6;
  logic [2:0]  red6;
  logic [2:0]  white6;
  logic [3:0]  gc6;
  logic        win6;
  logic        lose6;

  always #5 clk = ~clk;

  mastermind_scorer #(.PEGS(4), .COLOR_W(3), .MAX_GUESSES(8)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .start(start),
    .code(code_i), .guess(guess_i), .busy(busy), .done(done),
    .red(red), .white(white), .guess_count(gc), .win(win), .lose(lose)
  );

  mastermind_scorer #(.PEGS(6), .COLOR_W(4), .MAX_GUESSES(10)) dut6 (
    .clk(clk), .reset(reset), .new_game(new_game6), .start(start6),
    .code(code6), .guess(guess6), .busy(busy6), .done(done6),
    .red(red6), .white(white6), .guess_count(gc6), .win(win6), .lose(lose6)
  );

  int total = 0;
  int bad   = 0;

  // game-level model state
  int m_gc, m_win, m_lose;

  typedef struct {
    logic [11:0] c;
    logic [11:0] g;
    int          r;
    int          w;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pack4(input int a, input int b, input int c, input int d);
    logic [11:0] v;
    v = {d[2:0], c[2:0], b[2:0], a[2:0]};
    return v;
  endfunction

  // Red = equal positions; white = per-colour min of leftover counts.
  function automatic void ref_score(input logic [63:0] c, input logic [63:0] g,
                                    input int n, input int cw,
                                    output int r, output int w);
    int cc[16];
    int gg[16];
    int cv, gv;
    logic [63:0] mask;
    mask = (64'd1 << cw) - 64'd1;
    for (int k = 0; k < 16; k++) begin
      cc[k] = 0;
      gg[k] = 0;
    end
    r = 0;
    w = 0;
    for (int i = 0; i < n; i++) begin
      cv = int'((c >> (i*cw)) & mask);
      gv = int'((g >> (i*cw)) & mask);
      if (cv == gv) r++;
      else begin
        cc[cv]++;
        gg[gv]++;
      end
    end
    for (int k = 0; k < 16; k++) w += (cc[k] < gg[k]) ? cc[k] : gg[k];
  endfunction

  task automatic model_clear();
    m_gc = 0; m_win = 0; m_lose = 0;
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    model_clear();
  endtask

  // Score one guess on the 4-peg DUT and check every output.
  task automatic score4(input logic [11:0] c, input logic [11:0] g,
                        input int er, input int ew, input string tag);
    int lat;
    code_i  = c;
    guess_i = g;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, int'(busy), 1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 8);
    @(posedge clk); #1;
    m_gc   = (m_gc < 8) ? m_gc + 1 : 8;
    m_win  = (er == 4) ? 1 : 0;
    m_lose = (!m_win && m_gc == 8) ? 1 : 0;
    chk({tag, "_red"}, int'(red), er);
    chk({tag, "_white"}, int'(white), ew);
    chk({tag, "_gc"}, int'(gc), m_gc);
    chk({tag, "_win"}, int'(win), m_win);
    chk({tag, "_lose"}, int'(lose), m_lose);
    chk({tag, "_done_low"}, int'(done), 0);
  endtask

  // Start while the game is over: nothing may happen.
  task automatic ignored_start(input string tag);
    int nd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, int'(busy), 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    chk({tag, "_dones"}, nd, 0);
  endtask

  task automatic abort_seq(input bit use_reset, input string tag);
    int nd;
    do_new_game();
    score4(pack4(1,2,3,4), pack4(1,2,4,3), 2, 2, {tag, "_pre"});
    start = 1'b1;
    @(posedge clk); #1;            // edge k
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    if (use_reset) reset = 1'b1; else new_game = 1'b1;
    @(posedge clk); #1;            // edge k+4
    reset = 1'b0;
    new_game = 1'b0;
    model_clear();
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_red"}, int'(red), 0);
    chk({tag, "_white"}, int'(white), 0);
    chk({tag, "_gc"}, int'(gc), 0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    chk({tag, "_dones"}, nd, 0);
  endtask

  initial begin
    int r, w, nd, lat;
    logic [11:0] rc, rg;

    tbl[0] = '{pack4(1,2,3,4), pack4(4,3,2,1), 0, 4};
    tbl[1] = '{pack4(1,1,2,2), pack4(1,2,1,1), 1, 2};
    tbl[2] = '{pack4(5,5,5,5), pack4(5,0,0,0), 1, 0};
    tbl[3] = '{pack4(0,0,0,0), pack4(7,7,7,7), 0, 0};
    tbl[4] = '{pack4(1,2,3,4), pack4(1,2,3,5), 3, 0};
    tbl[5] = '{pack4(3,3,1,2), pack4(3,1,3,3), 1, 2};

    reset = 1'b1; new_game = 1'b0; start = 1'b0;
    code_i = '0; guess_i = '0;
    new_game6 = 1'b0; start6 = 1'b0; code6 = '0; guess6 = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_red", int'(red), 0);
    chk("rst_white", int'(white), 0);
    chk("rst_gc", int'(gc), 0);
    chk("rst_win", int'(win), 0);
    chk("rst_lose", int'(lose), 0);

    // table vectors
    for (int i = 0; i < 6; i++) score4(tbl[i].c, tbl[i].g, tbl[i].r, tbl[i].w, $sformatf("tbl%0d", i));

    // exact hit then further start is ignored
    do_new_game();
    score4(pack4(1,2,3,4), pack4(1,2,3,4), 4, 0, "hit");
    ignored_start("hit_after");
    chk("hit_after_gc", int'(gc), 1);

    // loss after eight misses
    do_new_game();
    for (int i = 0; i < 8; i++) score4(pack4(1,1,1,1), pack4(0,0,0,0), 0, 0, $sformatf("loss%0d", i));
    chk("loss_lose", int'(lose), 1);
    chk("loss_gc", int'(gc), 8);
    ignored_start("loss_9th");
    chk("loss_9th_gc", int'(gc), 8);
    do_new_game();
    chk("ng_lose", int'(lose), 0);
    chk("ng_gc", int'(gc), 0);
    chk("ng_red", int'(red), 0);
    score4(pack4(1,2,3,4), pack4(2,1,3,0), 1, 2, "ng_again");

    // abort by new_game and by reset
    abort_seq(1'b0, "abort_ng");
    abort_seq(1'b1, "abort_rst");

    // start while busy is not queued
    do_new_game();
    code_i = pack4(1,2,3,4); guess_i = pack4(4,3,2,1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      start = (i == 3) ? 1'b1 : 1'b0;
      if (done) nd++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("busy_start_dones", nd, 1);
    chk("busy_start_gc", int'(gc), 1);

    // input change during scoring
    do_new_game();
    rc = pack4(1,1,2,2); rg = pack4(2,1,1,3);
    ref_score(64'(rc), 64'(rg), 4, 3, r, w);
    code_i = rc; guess_i = rg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    code_i = pack4(7,7,7,7); guess_i = pack4(7,7,7,7);
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    @(posedge clk); #1;
    chk("chg_red", int'(red), r);
    chk("chg_white", int'(white), w);
    chk("chg_win", int'(win), 0);

    // new_game wins over start in the same cycle
    do_new_game();
    start = 1'b1; new_game = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; new_game = 1'b0;
    chk("ng_vs_start_busy", int'(busy), 0);

    // random guesses against the model
    do_new_game();
    for (int i = 0; i < 40; i++) begin
      if (m_win != 0 || m_lose != 0) do_new_game();
      for (int p = 0; p < 4; p++) begin
        rc[p*3 +: 3] = 3'($urandom_range(0, 3));
        rg[p*3 +: 3] = 3'($urandom_range(0, 3));
      end
      ref_score(64'(rc), 64'(rg), 4, 3, r, w);
      score4(rc, rg, r, w, $sformatf("rnd%0d", i));
    end

    // six-peg instance
    for (int p = 0; p < 6; p++) code6[p*4 +: 4] = 4'(p + 1);
    guess6 = {4'd1, 4'd5, 4'd4, 4'd3, 4'd2, 4'd6};
    start6 = 1'b1;
    @(posedge clk); #1;
    start6 = 1'b0;
    chk("p6_busy", int'(busy6), 1);
    lat = 0;
    while (!done6 && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("p6_latency", lat, 12);
    @(posedge clk); #1;
    chk("p6_red", int'(red6), 4);
    chk("p6_white", int'(white6), 2);
    chk("p6_gc", int'(gc6), 1);
    chk("p6_win", int'(win6), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mastermind_scorer.md
# mastermind_scorer

Parametrised, multi-cycle Mastermind feedback engine for the next game revision. It scores a guess against the secret code with correct duplicate-colour handling: each code peg and each guess peg is counted at most once. It also tracks the guess count and win/lose status. It sits between the game control FSM, which issues `start` once all guess pegs are loaded, and the HEX display decoders, which show `red` and `white`.

## Interface
Parameters:
- `PEGS`, 4: pegs per code/guess (≥1).
- `COLOR_W`, 3: bits per peg colour.
- `MAX_GUESSES`, 8: guesses allowed before loss (≥1).
- Derived: `CNT_W = $clog2(PEGS+1)`, `GC_W = $clog2(MAX_GUESSES+1)`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `new_game` in 1: clears results, guess count and win/lose; aborts any scoring in progress.
- `start` in 1: request scoring of `guess` against `code`.
- `code` in PEGS*COLOR_W: secret code; peg i = bits [i*COLOR_W +: COLOR_W], peg 0 in the LSBs.
- `guess` in PEGS*COLOR_W: guess, same packing as `code`.
- `busy` out 1: scoring in progress.
- `done` out 1: one-cycle pulse when `red`/`white` update.
- `red` out CNT_W: exact position+colour matches from the last scored guess.
- `white` out CNT_W: colour-only matches from the last scored guess.
- `guess_count` out GC_W: guesses scored in this game.
- `win` out 1: sticky; last guess had `red == PEGS`.
- `lose` out 1: sticky; `MAX_GUESSES` guesses scored without a win.

## Operation
States: IDLE, RED, WHITE, FINISH.

- **IDLE:**
  - `start` is accepted only when `win == 0` and `lose == 0`.
  - On acceptance: capture `code` and `guess` into internal registers; clear per-peg flags `code_used[PEGS]` and `guess_used[PEGS]`; clear accumulators `red_acc` and `white_acc` (CNT_W each); set `idx = 0`; go to RED.
  - While game over, `start` is ignored: no `busy`, no `done`.
- **RED (PEGS cycles, idx 0..PEGS-1):**
  - If `code_q[idx] == guess_q[idx]`: set `code_used[idx]` and `guess_used[idx]`; `red_acc += 1`.
  - At `idx == PEGS-1`: set `idx = 0` and go to WHITE; otherwise `idx += 1`.
- **WHITE (PEGS cycles):**
  - If `!guess_used[idx]`: find the lowest j with `!code_used[j]` and `code_q[j] == guess_q[idx]` (combinational priority encoder).
  - If such a j exists: set `code_used[j]`; `white_acc += 1`.
  - At `idx == PEGS-1`: go to FINISH; otherwise `idx += 1`.
- **FINISH (1 cycle):**
  - `red <= red_acc`, `white <= white_acc`, `done = 1`.
  - `guess_count` increments, saturating at `MAX_GUESSES`.
  - `win <= (red_acc == PEGS)`.
  - `lose <= !win_next && (guess_count + 1 == MAX_GUESSES)`.
  - Go to IDLE.
- `busy` = state ≠ IDLE.
- `code`/`guess` changes while busy have no effect; only the captured copies are used.
- Arithmetic:
  - Accumulators never exceed PEGS, so CNT_W is sufficient with no overflow.
  - Invariant: `red + white ≤ PEGS`.
- `new_game`:
  - Forces IDLE and clears `red`, `white`, `guess_count`, `win`, `lose`.
  - No `done` is pulsed for an aborted guess.
  - Takes priority over `start` in the same cycle; that `start` is dropped.
- `reset` takes priority over everything and behaves as `new_game`, plus it clears the internal registers.
- `start` while busy is ignored; it is not queued.

## Timing
- Reset values: `busy = 0`, `done = 0`, `red = 0`, `white = 0`, `guess_count = 0`, `win = 0`, `lose = 0`, state IDLE.
- `start` sampled high at edge k:
  - `busy` is high from cycle k+1 through k+2*PEGS+1.
  - `done` is high only in cycle k+2*PEGS+1.
  - `red`, `white`, `guess_count`, `win`, `lose` take their new values from cycle k+2*PEGS+2.
  - Latency is fixed at 2*PEGS+1 cycles (9 cycles for PEGS=4), independent of data.
- `done` is registered with FINISH; it is never high in consecutive cycles.
- Back-to-back: the next `start` is accepted in the first IDLE cycle after FINISH, so the minimum issue interval is 2*PEGS+2 cycles.
- `new_game` or `reset` asserted in cycle m: `busy` is low and outputs are cleared from cycle m+1.

## Test plan
- Exact hit, PEGS=4, COLOR_W=3: code {1,2,3,4}, guess {1,2,3,4}, start → `done` 9 cycles later; `red = 4`, `white = 0`, `win = 1`, `guess_count = 1`. A further `start` yields no `busy` and no `done`.
- Full permutation: code {1,2,3,4}, guess {4,3,2,1} → `red = 0`, `white = 4`, `win = 0`.
- Duplicates: code {1,1,2,2}, guess {1,2,1,1} → `red = 1`, `white = 2`. Also code {5,5,5,5}, guess {5,0,0,0} → `red = 1`, `white = 0`.
- Loss: 8 consecutive non-winning guesses → `lose = 1` on the 8th `done`, `guess_count = 8`. A 9th `start` is ignored. Then `new_game` → all outputs 0 and `start` is accepted again.
- Abort: `start`, then `new_game` at cycle k+4 → `busy = 0` at k+5, no `done` ever, `red`/`white`/`guess_count` = 0. Same sequence with `reset` in place of `new_game` → identical result.
- Ignore and parameter checks:
  - `start` pulsed while busy → exactly one `done`.
  - Changing `guess` mid-scoring does not alter the result.
  - Rerun with PEGS=6, COLOR_W=4, MAX_GUESSES=10, code {1,2,3,4,5,6}, guess {6,2,3,4,5,1} → `red = 4`, `white = 2`, `done` 13 cycles after `start`.
